// File: rtl/dmem_responder_if.sv
// Load/store port between the datapath (master) and the data memory (slave).
// Request: MemReq, MemWrite, Addr, WriteData. Response: ReadData, MemReady, MemError.
interface dmem_responder_if;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MemReady;
    logic        MemError;

    modport master (
        output MemReq, MemWrite, Addr, WriteData,
        input  ReadData, MemReady, MemError
    );

    modport slave (
        input  MemReq, MemWrite, Addr, WriteData,
        output ReadData, MemReady, MemError
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one word access at a time, completes LATENCY cycles
// after acceptance with a one-cycle MemReady pulse; all outputs registered.
// Ports: clk (rising edge), reset (sync, active-low), bus (slave side of
// dmem_responder_if). Optional macro DMEM_ALIGN_CHECK_EN adds the
// misaligned/out-of-range fault check driving MemError.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            we_q;
    logic [31:0]     wd_q;
    logic [AW-1:0]   idx_q;
    logic            flt_q;
    logic [31:0]     rdata_q;
    logic            ready_q;
    logic            err_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            acc_flt;

`ifdef DMEM_ALIGN_CHECK_EN
    // Addr >= 4*DEPTH_WORDS reduces to any bit set above the index field.
    assign acc_flt = (bus.Addr[1:0] != 2'b00) || (|bus.Addr[31:AW+2]);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.Addr[31:AW+2], bus.Addr[1:0]};
    assign acc_flt = 1'b0;
`endif

    // fin: this edge moves the FSM into DONE. With LATENCY = 1 that happens
    // straight from IDLE, so the access attributes come from the live inputs.
    logic            fin;
    logic            f_we;
    logic            f_flt;
    logic [AW-1:0]   f_idx;

    always_comb begin
        fin   = 1'b0;
        f_we  = we_q;
        f_flt = flt_q;
        f_idx = idx_q;
        if (state == IDLE) begin
            fin   = bus.MemReq && (LATENCY == 1);
            f_we  = bus.MemWrite;
            f_flt = acc_flt;
            f_idx = bus.Addr[AW+1:2];
        end else if (state == BUSY) begin
            fin   = (cnt == 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            wd_q    <= 32'h0;
            idx_q   <= '0;
            flt_q   <= 1'b0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= fin;
            err_q   <= fin && f_flt;
            if (fin && !f_we) begin
                rdata_q <= f_flt ? 32'h0 : mem[f_idx];
            end
            unique case (state)
                IDLE: begin
                    if (bus.MemReq) begin
                        we_q  <= bus.MemWrite;
                        wd_q  <= bus.WriteData;
                        idx_q <= bus.Addr[AW+1:2];
                        flt_q <= acc_flt;
                        if (LATENCY == 1) begin
                            state <= DONE;
                            cnt   <= 4'd0;
                        end else begin
                            state <= BUSY;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Store commits on the edge that leaves DONE, so a reset sampled in
    // that cycle still discards it. The array itself is never reset.
    always_ff @(posedge clk) begin
        if (reset && state == DONE && we_q && !flt_q) begin
            mem[idx_q] <= wd_q;
        end
    end

    assign bus.ReadData = rdata_q;
    assign bus.MemReady = ready_q;
`ifdef DMEM_ALIGN_CHECK_EN
    assign bus.MemError = err_q;
`else
    logic unused_err;
    assign unused_err     = err_q;
    assign bus.MemError   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver predicts acceptances and queues
// expected responses; a negedge monitor checks every MemReady pulse.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;
    localparam int AW    = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] rd;
        logic        err;
        int          due;
        int          widx;
        logic [31:0] old;
        logic        wrote;
    } exp_t;

    exp_t        sbq[$];
    exp_t        me;
    logic [31:0] model [DEPTH];
    logic [31:0] last_rd = 32'h0;
    int          cyc = 0;
    int          next_free = 0;
    int          compared = 0;
    int          mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: every MemReady must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (sbq.size() > 0 && cyc > sbq[0].due) begin
            compared++;
            mismatched++;
            $display("FAIL missing_ready: none by cycle %0d expected %0d",
                     cyc, sbq[0].due);
            void'(sbq.pop_front());
        end
        if (bus.MemReady !== 1'b0) begin
            if (sbq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_ready: got %b expected 0 (cycle %0d)",
                         bus.MemReady, cyc);
            end else begin
                me = sbq.pop_front();
                chk("latency", 32'(cyc), 32'(me.due));
                chk("readdata", bus.ReadData, me.rd);
                chk("memerror", 32'(bus.MemError), 32'(me.err));
            end
        end
    end

    function automatic logic is_fault(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
`else
        return 1'b0;
`endif
    endfunction

    task automatic accept(input logic we, input logic [31:0] a,
                          input logic [31:0] wd);
        exp_t e;
        int   idx;
        idx     = int'(a[AW+1:2]);
        e.we    = we;
        e.due   = cyc + LAT;
        e.err   = is_fault(a);
        e.widx  = idx;
        e.old   = 32'h0;
        e.wrote = 1'b0;
        if (we) begin
            if (!e.err) begin
                e.old      = model[idx];
                model[idx] = wd;
                e.wrote    = 1'b1;
            end
            e.rd = last_rd;
        end else begin
            last_rd = e.err ? 32'h0 : model[idx];
            e.rd    = last_rd;
        end
        sbq.push_back(e);
        next_free = cyc + LAT + 1;
    endtask

    task automatic step(input logic req, input logic we,
                        input logic [31:0] a, input logic [31:0] wd);
        bus.MemReq    = req;
        bus.MemWrite  = we;
        bus.Addr      = a;
        bus.WriteData = wd;
        if (req && reset && cyc >= next_free) accept(we, a, wd);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] a,
                         input logic [31:0] wd);
        bit acc;
        acc = 1'b0;
        while (!acc) begin
            acc = reset && (cyc >= next_free);
            step(1'b1, we, a, wd);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), $urandom, $urandom);
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        reset         = 1'b0;
        bus.MemReq    = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.Addr      = 32'h0000_0020;
        bus.WriteData = 32'h5A5A_5A5A;
        while (sbq.size() > 0) begin
            e = sbq.pop_back();
            if (e.wrote) model[e.widx] = e.old;
        end
        last_rd = 32'h0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("rst_ready", 32'(bus.MemReady), 32'h0);
            chk("rst_error", 32'(bus.MemError), 32'h0);
            chk("rst_rdata", bus.ReadData, 32'h0);
        end
        reset     = 1'b1;
        next_free = cyc;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
`ifdef DMEM_ALIGN_CHECK_EN
        if ($urandom_range(0, 7) != 0) a = {24'h0, a[5:0], 2'b00};
`endif
        return a;
    endfunction

    initial begin
        bus.MemReq    = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.Addr      = 32'h0;
        bus.WriteData = 32'hFFFF_FFFF;
        do_reset(3);

        for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom);

        issue(1'b1, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 32'h10, 32'h0);
        idle(1);

`ifdef DMEM_ALIGN_CHECK_EN
        issue(1'b1, 32'h13, 32'hAAAA5555);
        issue(1'b0, 32'h10, 32'h0);
        issue(1'b0, 32'h100, 32'h0);
`else
        issue(1'b1, 32'h100, 32'h12345678);
        issue(1'b0, 32'h0, 32'h0);
`endif
        idle(2);

        issue(1'b1, 32'h20, 32'hCAFEF00D);
        do_reset(2);
        issue(1'b0, 32'h20, 32'h0);
        idle(LAT + 1);

        for (int i = 0; i < 30; i++) step(1'b1, 1'($urandom), rand_addr(), $urandom);
        idle(LAT + 1);

        for (int i = 0; i < 200; i++) begin
            issue(1'($urandom), rand_addr(), $urandom);
            idle($urandom_range(0, 2));
        end
        idle(LAT + 3);

        compared++;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
